// File: rtl/gpu_pkg.sv
// Shared definitions for the tile-job dispatcher: job word field layout,
// dispatcher FSM encoding and a helper that assembles a job word.
package gpu_pkg;

  localparam int TEX_W = 8;
  localparam int SX_W  = 5;
  localparam int SY_W  = 5;
  localparam int Z_W   = 8;
  localparam int TX_W  = 6;
  localparam int TY_W  = 6;

  localparam int TEX_LSB = 0;
  localparam int SX_LSB  = TEX_LSB + TEX_W;
  localparam int SY_LSB  = SX_LSB + SX_W;
  localparam int Z_LSB   = SY_LSB + SY_W;
  localparam int TX_LSB  = Z_LSB + Z_W;
  localparam int TY_LSB  = TX_LSB + TX_W;
  localparam int JOB_W   = TY_LSB + TY_W;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [JOB_W-1:0] job_pack(
    input logic [TY_W-1:0]  tile_y,
    input logic [TX_W-1:0]  tile_x,
    input logic [Z_W-1:0]   pos_z,
    input logic [SY_W-1:0]  start_y,
    input logic [SX_W-1:0]  start_x,
    input logic [TEX_W-1:0] texture_idx
  );
    job_pack = {tile_y, tile_x, pos_z, start_y, start_x, texture_idx};
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous job buffer; the head word is visible combinationally so the
// dispatcher can register it on the same edge that pops it.
module job_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sm_job_dispatcher.sv
// Buffers tile render jobs and hands them round-robin to idle shading units,
// tracking per-unit ownership and signalling when a whole frame has retired.
module sm_job_dispatcher #(
  parameter int NUM_SM     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int JOB_W      = gpu_pkg::JOB_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_enable,
  input  logic              i_job_valid,
  output logic              o_job_ready,
  input  logic [JOB_W-1:0]  i_job_data,
  input  logic              i_job_last,
  output logic [NUM_SM-1:0] o_sm_start,
  output logic [JOB_W-1:0]  o_sm_job,
  input  logic [NUM_SM-1:0] i_sm_done,
  output logic [NUM_SM-1:0] o_busy_mask,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt,
  output logic              o_err
);

  import gpu_pkg::*;

  localparam int RR_W = $clog2(NUM_SM);

  state_e            state_q, state_d;
  logic [NUM_SM-1:0] busy_q, busy_d;
  logic [NUM_SM-1:0] start_q, start_d;
  logic [JOB_W-1:0]  job_q, job_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;
  logic              last_out_q, last_out_d;

  logic              fifo_full, fifo_empty;
  logic [JOB_W:0]    fifo_head;
  logic              accept, dispatch;
  logic              hi_found, lo_found;
  logic [RR_W-1:0]   hi_idx, lo_idx, grant_idx;

  assign o_job_ready = i_enable & ~fifo_full & (state_q == S_RUN);
  assign accept      = i_job_valid & o_job_ready;

  job_fifo #(
    .WIDTH (JOB_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (accept),
    .pop_i   (dispatch),
    .data_i  ({i_job_last, i_job_data}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Scan downward so the last hit is the lowest index: hi_* is the first idle
  // unit at or after rr_q, lo_* the first idle unit overall (the wrap case).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_SM - 1; k >= 0; k--) begin
      if (!busy_q[k]) begin
        lo_found = 1'b1;
        lo_idx   = RR_W'(k);
        if (k >= int'(rr_q)) begin
          hi_found = 1'b1;
          hi_idx   = RR_W'(k);
        end
      end
    end
  end

  assign grant_idx = hi_found ? hi_idx : lo_idx;
  assign dispatch  = i_enable & ~fifo_empty & lo_found;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q & ~i_sm_done;
    start_d      = '0;
    job_d        = '0;
    rr_d         = rr_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q | (|(i_sm_done & ~busy_q));
    last_out_d   = last_out_q;

    if (dispatch) begin
      start_d = NUM_SM'(1) << grant_idx;
      busy_d  = busy_d | start_d;
      job_d   = fifo_head[JOB_W-1:0];
      rr_d    = (grant_idx == RR_W'(NUM_SM - 1)) ? '0 : grant_idx + 1'b1;
      if (fifo_head[JOB_W]) last_out_d = 1'b1;
    end

    case (state_q)
      S_RUN: begin
        if (accept && i_job_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && (busy_q == '0) && last_out_q) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d    = S_RUN;
        last_out_d = 1'b0;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      busy_q       <= '0;
      start_q      <= '0;
      job_q        <= '0;
      rr_q         <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
      last_out_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      job_q        <= job_d;
      rr_q         <= rr_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      last_out_q   <= last_out_d;
    end
  end

  assign o_sm_start   = start_q;
  assign o_sm_job     = job_q;
  assign o_busy_mask  = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_sm_job_dispatcher.sv
// Directed scoreboard bench: stimulus queues the hand-derived SM/job of every
// expected start; a negedge monitor pops and compares each start it observes.
module tb_sm_job_dispatcher;

  import gpu_pkg::*;

  localparam int NUM_SM = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_enable;
  logic              i_job_valid;
  logic              o_job_ready;
  logic [JOB_W-1:0]  i_job_data;
  logic              i_job_last;
  logic [NUM_SM-1:0] o_sm_start;
  logic [JOB_W-1:0]  o_sm_job;
  logic [NUM_SM-1:0] i_sm_done;
  logic [NUM_SM-1:0] o_busy_mask;
  logic              o_frame_done;
  logic [7:0]        o_frame_cnt;
  logic              o_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NUM_SM-1:0] sm;
    logic [JOB_W-1:0]  job;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  sm_job_dispatcher #(.NUM_SM(NUM_SM), .FIFO_DEPTH(4), .JOB_W(JOB_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .i_job_valid  (i_job_valid),
    .o_job_ready  (o_job_ready),
    .i_job_data   (i_job_data),
    .i_job_last   (i_job_last),
    .o_sm_start   (o_sm_start),
    .o_sm_job     (o_sm_job),
    .i_sm_done    (i_sm_done),
    .o_busy_mask  (o_busy_mask),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [JOB_W-1:0] mk(input int n);
    mk = job_pack(6'(n), 6'(n + 7), 8'(n * 5 + 1), 5'(n + 3), 5'(n * 2), 8'(n + 100));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [JOB_W-1:0] d, input logic last);
    int n;
    n = 0;
    i_job_valid = 1'b1;
    i_job_data  = d;
    i_job_last  = last;
    @(negedge clk);
    while (!o_job_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!o_job_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready 0 after 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    i_job_valid = 1'b0;
    i_job_last  = 1'b0;
    i_job_data  = '0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_sm_start != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got %b expected no start", o_sm_start);
        end else begin
          mon_e = exp_q.pop_front();
          chk("start_sm", 64'(o_sm_start), 64'(mon_e.sm));
          chk("start_job", 64'(o_sm_job), 64'(mon_e.job));
        end
      end else begin
        chk("idle_job_zero", 64'(o_sm_job), 64'(0));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NUM_SM-1:0] m;

    reset_n = 1'b0; i_enable = 1'b1; i_job_valid = 1'b0;
    i_job_data = '0; i_job_last = 1'b0; i_sm_done = '0;
    tick(3);
    chk("rst_ready", 64'(o_job_ready), 64'(1));
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    chk("init_ready", 64'(o_job_ready), 64'(1));
    chk("init_busy", 64'(o_busy_mask), 64'(0));
    chk("init_start", 64'(o_sm_start), 64'(0));
    chk("init_cnt", 64'(o_frame_cnt), 64'(0));
    chk("init_err", 64'(o_err), 64'(0));
    chk("init_fdone", 64'(o_frame_done), 64'(0));

    // Round-robin fill: four starts in order, two jobs left queued
    for (int j = 0; j < 6; j++) begin
      if (j < 4) exp_q.push_back('{sm: NUM_SM'(1 << j), job: mk(j)});
      send(mk(j), 1'b0);
    end
    tick(3);
    chk("rr_busy_full", 64'(o_busy_mask), 64'(4'b1111));
    send(mk(6), 1'b0);
    send(mk(7), 1'b0);
    @(negedge clk);
    chk("ready_fifo_full", 64'(o_job_ready), 64'(0));
    @(posedge clk); #1;

    // Recycle SM2: its done cycle and the next must show no start
    exp_q.push_back('{sm: 4'b0100, job: mk(4)});
    i_sm_done = 4'b0100;
    @(negedge clk);
    chk("recycle_T", 64'(o_sm_start), 64'(0));
    @(posedge clk); #1;
    i_sm_done = '0;
    @(negedge clk);
    chk("recycle_T1", 64'(o_sm_start), 64'(0));
    @(negedge clk);
    chk("recycle_T2", 64'(o_sm_start), 64'(4'b0100));
    @(posedge clk); #1;

    // Two SMs freed together; rr=3 wraps to SM0 then SM1
    exp_q.push_back('{sm: 4'b0001, job: mk(5)});
    exp_q.push_back('{sm: 4'b0010, job: mk(6)});
    i_sm_done = 4'b0011;
    tick(1);
    i_sm_done = '0;
    tick(4);
    chk("dual_busy", 64'(o_busy_mask), 64'(4'b1111));

    // Frame end: last job accepted, drain, then one-cycle frame_done
    exp_q.push_back('{sm: 4'b0100, job: mk(7)});
    exp_q.push_back('{sm: 4'b1000, job: mk(8)});
    send(mk(8), 1'b1);
    @(negedge clk);
    chk("drain_ready0", 64'(o_job_ready), 64'(0));
    @(posedge clk); #1;
    i_sm_done = 4'b1111;
    tick(1);
    i_sm_done = '0;
    tick(4);
    chk("drain_busy", 64'(o_busy_mask), 64'(4'b1100));
    chk("drain_ready1", 64'(o_job_ready), 64'(0));
    i_sm_done = 4'b1100;
    @(negedge clk);
    chk("fd_early0", 64'(o_frame_done), 64'(0));
    @(posedge clk); #1;
    i_sm_done = '0;
    @(negedge clk);
    chk("fd_busy0", 64'(o_busy_mask), 64'(0));
    chk("fd_early1", 64'(o_frame_done), 64'(0));
    chk("drain_ready2", 64'(o_job_ready), 64'(0));
    @(negedge clk);
    chk("fd_pulse", 64'(o_frame_done), 64'(1));
    chk("fd_cnt1", 64'(o_frame_cnt), 64'(1));
    chk("done_ready0", 64'(o_job_ready), 64'(0));
    @(negedge clk);
    chk("fd_end", 64'(o_frame_done), 64'(0));
    chk("run_ready", 64'(o_job_ready), 64'(1));
    @(posedge clk); #1;

    // Enable gating with J13,J14 queued behind four busy SMs
    for (int j = 9; j < 15; j++) begin
      if (j < 13) exp_q.push_back('{sm: NUM_SM'(1 << (j - 9)), job: mk(j)});
      send(mk(j), 1'b0);
    end
    i_enable = 1'b0;
    @(negedge clk);
    chk("gate_ready", 64'(o_job_ready), 64'(0));
    @(posedge clk); #1;
    i_sm_done = 4'b0001;
    tick(1);
    i_sm_done = '0;
    tick(3);
    @(negedge clk);
    chk("gate_busy", 64'(o_busy_mask), 64'(4'b1110));
    @(posedge clk); #1;
    exp_q.push_back('{sm: 4'b0001, job: mk(13)});
    i_enable = 1'b1;
    @(negedge clk);
    chk("resume_R", 64'(o_sm_start), 64'(0));
    @(negedge clk);
    chk("resume_R1", 64'(o_sm_start), 64'(4'b0001));
    @(posedge clk); #1;

    // Error: done from idle SM3 while only SM1 is busy
    exp_q.push_back('{sm: 4'b0010, job: mk(14)});
    i_sm_done = 4'b1111;
    tick(1);
    i_sm_done = '0;
    tick(3);
    chk("pre_err_busy", 64'(o_busy_mask), 64'(4'b0010));
    chk("pre_err", 64'(o_err), 64'(0));
    i_sm_done = 4'b1000;
    tick(1);
    i_sm_done = '0;
    @(negedge clk);
    chk("err_set", 64'(o_err), 64'(1));
    chk("err_busy", 64'(o_busy_mask), 64'(4'b0010));
    @(posedge clk); #1;
    i_sm_done = 4'b0010;
    tick(1);
    i_sm_done = '0;
    tick(2);
    chk("err_busy_clear", 64'(o_busy_mask), 64'(0));
    chk("err_sticky", 64'(o_err), 64'(1));

    // Single-job frames until the counter wraps 255 -> 0; rr starts at 2
    for (int i = 0; i < 255; i++) begin
      m = NUM_SM'(1 << ((2 + i) % NUM_SM));
      exp_q.push_back('{sm: m, job: mk(20 + i)});
      send(mk(20 + i), 1'b1);
      tick(1);
      i_sm_done = m;
      tick(1);
      i_sm_done = '0;
      n = 0;
      while (!o_frame_done && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!o_frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_timeout: frame %0d got 0 expected 1", i);
      end
      if (i == 253) chk("cnt_255", 64'(o_frame_cnt), 64'(255));
      if (i == 254) chk("cnt_wrap", 64'(o_frame_cnt), 64'(0));
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-dispatch: rr=1, JA starting on SM1, JB queued
    send(mk(300), 1'b0);
    send(mk(301), 1'b0);
    chk("pre_rst_start", 64'(o_sm_start), 64'(4'b0010));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_start", 64'(o_sm_start), 64'(0));
    chk("arst_job", 64'(o_sm_job), 64'(0));
    chk("arst_busy", 64'(o_busy_mask), 64'(0));
    chk("arst_err", 64'(o_err), 64'(0));
    chk("arst_cnt", 64'(o_frame_cnt), 64'(0));
    chk("arst_fdone", 64'(o_frame_done), 64'(0));
    chk("arst_ready", 64'(o_job_ready), 64'(1));
    @(negedge clk);
    reset_n = 1'b1;
    tick(4);
    chk("post_rst_busy", 64'(o_busy_mask), 64'(0));
    chk("post_rst_ready", 64'(o_job_ready), 64'(1));
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
